// File: rtl/aq_clint_pkg.sv
// Shared definitions for the CLINT timer unit: register offsets, FSM states, compare width.
// Optional feature macro used by this slice: AQ_CLINT_STIMECMP_EN (supervisor timer compare).
package aq_clint_pkg;

    localparam int CMP_W = 64;

    localparam logic [2:0] MSIP     = 3'd0;
    localparam logic [2:0] SSIP     = 3'd1;
    localparam logic [2:0] MTCMP_LO = 3'd2;
    localparam logic [2:0] MTCMP_HI = 3'd3;
    localparam logic [2:0] STCMP_LO = 3'd4;
    localparam logic [2:0] STCMP_HI = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } clint_state_t;

endpackage

// File: rtl/aq_clint_cmp.sv
// 64-bit timer compare register with independent 32-bit half writes and a registered
// unsigned (mtime >= cmp) flag. The flag is level-sensitive: it follows the compare every cycle.
module aq_clint_cmp
    import aq_clint_pkg::*;
#(
    parameter logic [CMP_W-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [CMP_W-1:0] mtime,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic [31:0]      wdata,
    output logic [CMP_W-1:0] cmp_val,
    output logic             int_flag
);

    logic [CMP_W-1:0] cmp_q;
    logic             int_q;

    // Compare register update; reset wins over a coincident write so no partial write survives.
    always_ff @(posedge clk) begin
        if (srst) begin
            cmp_q <= RST_VAL;
        end else begin
            if (wr_lo) cmp_q[31:0]  <= wdata;
            if (wr_hi) cmp_q[63:32] <= wdata;
        end
    end

    // Registered compare against the currently held value; a new cmp is seen one cycle after its write.
    always_ff @(posedge clk) begin
        if (srst) begin
            int_q <= 1'b0;
        end else begin
            int_q <= (mtime >= cmp_q);
        end
    end

    assign cmp_val  = cmp_q;
    assign int_flag = int_q;

endmodule

// File: rtl/aq_clint_tmr.sv
// Per-hart CLINT timer / software-interrupt unit with a 32-bit request/ack register port
// paced by apb_clk_en. Define AQ_CLINT_STIMECMP_EN to include the supervisor timer compare.
module aq_clint_tmr
    import aq_clint_pkg::*;
#(
    parameter logic [CMP_W-1:0] CMP_RST_VAL = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst,
    input  logic             apb_clk_en,
    input  logic [CMP_W-1:0] sysio_clint_mtime,
    input  logic             tmr_req,
    input  logic             tmr_wr,
    input  logic [2:0]       tmr_addr,
    input  logic [31:0]      tmr_wdata,
    output logic [31:0]      tmr_rdata,
    output logic             tmr_ack,
    output logic             tmr_err,
    output logic             clint_core0_ms_int,
    output logic             clint_core0_ss_int,
    output logic             clint_core0_mt_int,
    output logic             clint_core0_st_int
);

    clint_state_t     state_q, state_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             msip_q, ssip_q;
    logic             ms_int_q, ss_int_q;
    logic             accept;
    logic             wr_en;
    logic [31:0]      rd_val;
    logic             addr_err;
    logic [CMP_W-1:0] mtcmp, stcmp;

    // A new access is only taken from IDLE on an enable edge; requests seen in RESP are ignored.
    assign accept = (state_q == IDLE) && tmr_req && apb_clk_en;
    assign wr_en  = accept && tmr_wr && !addr_err;

    // Read mux and unmapped-offset decode for the offset currently presented.
    always_comb begin
        rd_val   = '0;
        addr_err = 1'b0;
        case (tmr_addr)
            MSIP:     rd_val = {31'b0, msip_q};
            SSIP:     rd_val = {31'b0, ssip_q};
            MTCMP_LO: rd_val = mtcmp[31:0];
            MTCMP_HI: rd_val = mtcmp[63:32];
            STCMP_LO: rd_val = stcmp[31:0];
            STCMP_HI: rd_val = stcmp[63:32];
            default:  addr_err = 1'b1;
        endcase
    end

    // Next state, captured response and ack; writes return zero read data.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tmr_ack = (state_q == RESP);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RESP;
                    rdata_d = tmr_wr ? 32'h0 : rd_val;
                    err_d   = addr_err;
                end
            end
            RESP: begin
                if (apb_clk_en) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, response registers, software-interrupt bits and their registered int copies.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q  <= IDLE;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            msip_q   <= 1'b0;
            ssip_q   <= 1'b0;
            ms_int_q <= 1'b0;
            ss_int_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            if (wr_en && tmr_addr == MSIP) msip_q <= tmr_wdata[0];
            if (wr_en && tmr_addr == SSIP) ssip_q <= tmr_wdata[0];
            ms_int_q <= msip_q;
            ss_int_q <= ssip_q;
        end
    end

    aq_clint_cmp #(
        .RST_VAL (CMP_RST_VAL)
    ) u_mtcmp (
        .clk      (forever_cpuclk),
        .srst     (cpurst),
        .mtime    (sysio_clint_mtime),
        .wr_lo    (wr_en && tmr_addr == MTCMP_LO),
        .wr_hi    (wr_en && tmr_addr == MTCMP_HI),
        .wdata    (tmr_wdata),
        .cmp_val  (mtcmp),
        .int_flag (clint_core0_mt_int)
    );

`ifdef AQ_CLINT_STIMECMP_EN
    aq_clint_cmp #(
        .RST_VAL (CMP_RST_VAL)
    ) u_stcmp (
        .clk      (forever_cpuclk),
        .srst     (cpurst),
        .mtime    (sysio_clint_mtime),
        .wr_lo    (wr_en && tmr_addr == STCMP_LO),
        .wr_hi    (wr_en && tmr_addr == STCMP_HI),
        .wdata    (tmr_wdata),
        .cmp_val  (stcmp),
        .int_flag (clint_core0_st_int)
    );
`else
    // Without the supervisor compare, offsets 4/5 stay mapped but read zero and ignore writes.
    assign stcmp              = '0;
    assign clint_core0_st_int = 1'b0;
`endif

    assign tmr_rdata          = rdata_q;
    assign tmr_err            = err_q;
    assign clint_core0_ms_int = ms_int_q;
    assign clint_core0_ss_int = ss_int_q;

endmodule
